// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding and bus constants.
// Used by i2c_slave and its line synchronizer.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_WR_DATA  = 4'd3,
        ST_WR_ACK   = 4'd4,
        ST_RD_DATA  = 4'd5,
        ST_RD_ACK   = 4'd6,
        ST_IGNORE   = 4'd7
    } i2c_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [3:0] LAST_RX_BIT = 4'd7;
    localparam logic [3:0] LAST_TX_BIT = 4'd8;

    function automatic logic addr_hit(input logic [7:0] b,
                                      input logic [6:0] a);
        return b[7:1] == a;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: SCL/SDA synchronizers, history flops and
// edge/START/STOP detection for the I2C responder.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_s;
    logic                   scl_h;
    logic                   sda_h;

    // Synchronizer chains plus one history flop; idle bus is high
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_in};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_in};
            scl_h  <= scl_s;
            sda_h  <= sda_s;
        end
    end

    assign scl_s = scl_ff[SYNC_STAGES-1];
    assign sda_s = sda_ff[SYNC_STAGES-1];

    assign scl_rise  =  scl_s & ~scl_h;
    assign scl_fall  = ~scl_s &  scl_h;
    assign start_det =  scl_s &  scl_h & ~sda_s &  sda_h;
    assign stop_det  =  scl_s &  scl_h &  sda_s & ~sda_h;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with 7-bit address match.
// Optional clock stretching: I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       rd_req,
    input  logic [7:0] rd_data,
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    input  logic       wr_ready,
`endif
    output logic       busy,
    output logic [3:0] state
);

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       sda_s;

    i2c_state_t st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] sr_q, sr_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_valid_q, wr_valid_d;
    logic       rd_req_q, rd_req_d;
    logic [7:0] rx_byte;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic       scl_oe_q, scl_oe_d;
`endif

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    // Seven stored bits plus the bit arriving now form a byte
    assign rx_byte = {sr_q, sda_s};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q       <= ST_IDLE;
            cnt_q      <= 4'd0;
            sr_q       <= 7'd0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_data_q  <= 8'd0;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_q   <= 1'b0;
`endif
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            rd_req_q   <= rd_req_d;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_q   <= scl_oe_d;
`endif
        end
    end

    // Next-state and output decode; bus conditions override bit flow
    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_data_d = wr_data_q;
        rd_req_d  = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        wr_valid_d = wr_valid_q & ~wr_ready;
        scl_oe_d   = scl_oe_q;
`else
        wr_valid_d = 1'b0;
`endif

        if (start_det) begin
            st_d     = ST_ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_d = 1'b0;
`endif
        end else if (stop_det) begin
            st_d     = ST_IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_d = 1'b0;
`endif
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        sr_d = rx_byte[6:0];
                        if (cnt_q == LAST_RX_BIT) begin
                            cnt_d = 4'd0;
                            if (addr_hit(rx_byte, ADDR)) begin
                                st_d   = ST_ADDR_ACK;
                                busy_d = 1'b1;
                                rw_d   = rx_byte[0];
                            end else begin
                                st_d   = ST_IGNORE;
                                busy_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end

                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_rise && sda_oe_q &&
                        st_q == ST_ADDR_ACK && rw_q) begin
                        rd_req_d = 1'b1;
                    end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                    if (st_q == ST_WR_ACK) begin
                        if (scl_fall && wr_valid_q && !wr_ready)
                            scl_oe_d = 1'b1;
                        if (scl_oe_q && wr_ready)
                            scl_oe_d = 1'b0;
                    end
`endif
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            if (st_q == ST_ADDR_ACK && rw_q) begin
                                st_d = ST_RD_DATA;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                                scl_oe_d = 1'b1;
`else
                                sr_d     = rd_data[6:0];
                                sda_oe_d = ~rd_data[7];
                                cnt_d    = 4'd1;
`endif
                            end else begin
                                st_d = ST_WR_DATA;
                            end
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (scl_rise) begin
                        sr_d = rx_byte[6:0];
                        if (cnt_q == LAST_RX_BIT) begin
                            wr_data_d  = rx_byte;
                            wr_valid_d = 1'b1;
                            st_d       = ST_WR_ACK;
                            cnt_d      = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end

                ST_RD_DATA: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                    if (scl_oe_q && cnt_q == 4'd0) begin
                        sr_d     = rd_data[6:0];
                        sda_oe_d = ~rd_data[7];
                        cnt_d    = 4'd1;
                        scl_oe_d = 1'b0;
                    end else if (scl_fall && cnt_q == 4'd0) begin
                        scl_oe_d = 1'b1;
                    end else
`else
                    if (scl_fall && cnt_q == 4'd0) begin
                        sr_d     = rd_data[6:0];
                        sda_oe_d = ~rd_data[7];
                        cnt_d    = 4'd1;
                    end else
`endif
                    if (scl_fall) begin
                        if (cnt_q == LAST_TX_BIT) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            st_d     = ST_RD_ACK;
                        end else begin
                            sda_oe_d = ~sr_q[6];
                            sr_d     = {sr_q[5:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end

                ST_RD_ACK: begin
                    sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        if (sda_s == NACK) begin
                            st_d = ST_IGNORE;
                        end else begin
                            rd_req_d = 1'b1;
                            st_d     = ST_RD_DATA;
                            cnt_d    = 4'd0;
                        end
                    end
                end

                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    st_d     = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
    assign rd_req   = rd_req_q;
    assign busy     = busy_q;
    assign state    = st_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    assign scl_oe   = scl_oe_q;
`else
    assign scl_oe   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bus-level master driving i2c_slave, with a
// transaction-level expectation model and random traffic.
module tb_i2c_slave;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] rd_data = 8'd0;
    logic       scl_line;
    logic       sda_line;
    logic       sda_oe;
    logic       scl_oe;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       rd_req;
    logic       busy;
    logic [3:0] state;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic       wr_ready = 1'b1;
`endif

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int oe_cnt = 0;

    assign scl_line = scl_m & ~scl_oe;
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave #(
        .ADDR        (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .scl_in   (scl_line),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .scl_oe   (scl_oe),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        .wr_ready (wr_ready),
`endif
        .busy     (busy),
        .state    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_valid) wr_cnt <= wr_cnt + 1;
        if (rd_req)   rd_cnt <= rd_cnt + 1;
        if (sda_oe)   oe_cnt <= oe_cnt + 1;
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b; wq();
        scl_m = 1'b1; wq();
        r = sda_line; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] nxt,
                             output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        rd_data = nxt;
        clock_bit(mack, r);
    endtask

    logic       ack;
    logic [7:0] got;
    logic [7:0] exp_wr;
    logic [7:0] bytes [0:3];
    logic [6:0] a7;
    logic       rw;
    logic       hit;
    int         n;
    int         w0, r0, o0;

    initial begin
        exp_wr = 8'h00;

        // reset state
        repeat (4) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        wq();

        // write A0, AA, stop
        w0 = wr_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        chk("w1_addr_ack", ack, 0);
        chk("w1_busy", busy, 1);
        write_byte(8'hAA, ack);
        chk("w1_data_ack", ack, 0);
        exp_wr = 8'hAA;
        chk("w1_wr_data", wr_data, exp_wr);
        chk("w1_wr_valid_n", wr_cnt - w0, 1);
        bus_stop();
        chk("w1_busy_after", busy, 0);
        chk("w1_idle", state, 0);

        // foreign address
        w0 = wr_cnt; o0 = oe_cnt;
        bus_start();
        write_byte(8'hA4, ack);
        chk("na_state", state, 7);
        write_byte(8'h5A, ack);
        bus_stop();
        chk("na_oe_never", oe_cnt - o0, 0);
        chk("na_wr_valid", wr_cnt - w0, 0);
        chk("na_idle", state, 0);
        chk("na_wr_data", wr_data, exp_wr);

        // read CC (ack) then F0 (nack)
        r0 = rd_cnt;
        rd_data = 8'hCC;
        bus_start();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", ack, 0);
        read_byte(1'b0, 8'hF0, got);
        chk("rd_byte0", got, 8'hCC);
        read_byte(1'b1, 8'h00, got);
        chk("rd_byte1", got, 8'hF0);
        chk("rd_ignore", state, 7);
        chk("rd_req_n", rd_cnt - r0, 2);
        bus_stop();
        chk("rd_idle", state, 0);

        // write then repeated START into a read
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h11, ack);
        chk("rs_wr_ack", ack, 0);
        exp_wr = 8'h11;
        chk("rs_wr_data", wr_data, exp_wr);
        rd_data = 8'h3C;
        bus_start();
        write_byte(8'hA1, ack);
        chk("rs_addr_ack", ack, 0);
        chk("rs_rd_state", state, 5);
        read_byte(1'b1, 8'h00, got);
        chk("rs_rd_byte", got, 8'h3C);
        bus_stop();

        // stop in the middle of a data byte
        w0 = wr_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) clock_bit(i[0], ack);
        bus_stop();
        chk("pb_idle", state, 0);
        chk("pb_wr_data", wr_data, exp_wr);
        chk("pb_sda_oe", sda_oe, 0);
        chk("pb_wr_valid", wr_cnt - w0, 0);

        // reset while ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            a7 = 7'h50;
            clock_bit(i == 0 ? 1'b0 : a7[i-1], ack);
        end
        chk("ra_driving", sda_oe, 1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("ra_sda_oe", sda_oe, 0);
        chk("ra_state", state, 0);
        @(negedge clk) rst_n = 1'b1;
        exp_wr = 8'h00;
        wq();
        bus_start();
        write_byte(8'hA0, ack);
        chk("ra_addr_ack", ack, 0);
        write_byte(8'h77, ack);
        exp_wr = 8'h77;
        chk("ra_wr_data", wr_data, exp_wr);
        bus_stop();

        // random transactions against the expectation model
        for (int k = 0; k < 8; k++) begin
            a7  = $urandom_range(0, 1) ? 7'h50 : 7'($urandom_range(0, 127));
            rw  = 1'($urandom_range(0, 1));
            hit = (a7 == 7'h50);
            n   = $urandom_range(1, 3);
            for (int j = 0; j < 4; j++) bytes[j] = 8'($urandom);
            w0 = wr_cnt; r0 = rd_cnt;
            rd_data = bytes[0];
            bus_start();
            write_byte({a7, rw}, ack);
            chk("rnd_addr_ack", ack, hit ? 0 : 1);
            if (hit && rw) begin
                for (int j = 0; j < n; j++) begin
                    read_byte(j == n - 1, bytes[j+1], got);
                    chk("rnd_rd_byte", got, bytes[j]);
                end
                chk("rnd_rd_req", rd_cnt - r0, n);
            end else if (!rw) begin
                for (int j = 0; j < n; j++) begin
                    write_byte(bytes[j], ack);
                    chk("rnd_wr_ack", ack, hit ? 0 : 1);
                end
                if (hit) exp_wr = bytes[n-1];
                chk("rnd_wr_data", wr_data, exp_wr);
                chk("rnd_wr_valid", wr_cnt - w0, hit ? n : 0);
            end
            bus_stop();
            chk("rnd_idle", state, 0);
            chk("rnd_busy", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder (target) for the bus driven by i2c_master; same system clock domain; SCL/SDA are oversampled, with no SCL-derived clocks.
- Detects START/STOP, matches a 7-bit address, ACKs, and shifts write bytes out to a local register interface.
- Serves read bytes from a local source through a req/data handshake.
- Open-drain: the block only ever drives lines low (oe=1 means pull low).

Parameters:
- ADDR, 7'h50, this device's 7-bit bus address.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (min 2).

Ports:
- clk  in  1  system clock (≥10x SCL rate).
- reset  in  1  synchronous, active-low reset.
- scl_in  in  1  SCL line level.
- sda_in  in  1  SDA line level.
- sda_oe  out  1  1 = pull SDA low.
- scl_oe  out  1  1 = pull SCL low (clock stretch; see Optional Feature).
- wr_data  out  8  last byte written by master.
- wr_valid  out  1  1-clk pulse, wr_data new.
- rd_req  out  1  1-clk pulse, next read byte wanted.
- rd_data  in  8  read byte; must be stable by next SCL falling edge after rd_req.
- busy  out  1  addressed transaction in progress.
- state  out  4  FSM state, for debug.

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE; sda_oe=0, scl_oe=0, wr_data=0, wr_valid=0, rd_req=0, busy=0; bit counter=0. Reset mid-transfer releases the bus on the same edge.
- Sync: SYNC_STAGES flops, plus one history flop per line. Edge/condition flags assert one clk after the synchronized change.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high. Both are checked in every state, including after a repeated START.
- Data sampled on SCL rising edge, MSB first. Outputs change only on SCL falling edge.
- FSM encodings: IDLE=0, ADDR=1, ADDR_ACK=2, WR_DATA=3, WR_ACK=4, RD_DATA=5, RD_ACK=6, IGNORE=7.
- IDLE: START -> ADDR, count=0.
- ADDR: shift 8 bits.
  - After the 8th rising edge: if byte[7:1]==ADDR -> ADDR_ACK and busy=1; else -> IGNORE.
  - rw = byte[0].
- ADDR_ACK: sda_oe=1 from the next SCL fall to the following SCL fall. On that release fall -> WR_DATA (rw=0) or RD_DATA (rw=1).
  - If rw=1, rd_req pulses on the ACK-bit SCL rise. rd_data is latched into the shift register at the release fall, and MSB is driven on the same clk.
- WR_DATA: shift 8 bits. On the 8th rise, wr_data<=byte and wr_valid=1 for 1 clk. Then -> WR_ACK.
- WR_ACK: always ACK, with the same timing as ADDR_ACK. Then -> WR_DATA with count=0.
- RD_DATA: sda_oe = ~shift[7] on each SCL fall; 8 bits. After the 8th fall, sda_oe=0 -> RD_ACK.
- RD_ACK: sample SDA on SCL rise.
  - 0 (master ACK): rd_req pulse, -> RD_DATA.
  - 1 (NACK): -> IGNORE.
- IGNORE: sda_oe=0; wait for START (-> ADDR) or STOP (-> IDLE).
- STOP anywhere -> IDLE: busy=0, sda_oe=0.
- START anywhere -> ADDR: count=0, sda_oe=0.
- Simultaneous START and SCL-edge flags: START wins.
- Partial byte at STOP/START is discarded; no wr_valid.
- Bit counter is 4 bits. It wraps to 0 at each ACK state entry, never past 8.
- The slave never drives SDA while SCL is high except when holding ACK or data through the high phase.

Optional Feature:
- Macro I2C_SLAVE_CLK_STRETCH_EN.
- Defined: after rd_req, scl_oe=1 at the following SCL fall, held until rd_data is latched (latency = rd_data stable next clk). Likewise, wr_valid is held with scl_oe=1 through the WR_ACK fall until a new input wr_ready=1; the wr_ready port exists only under this macro.
- Undefined: scl_oe tied 0; no wr_ready port; timing exactly as above.

Decomposition:
- Package i2c_pkg: FSM state localparams (shared encoding with i2c_master debug state), ACK=1'b0, NACK=1'b1.
- Sub-module i2c_line_sync: synchronizer plus edge/START/STOP detection. It is instanced once and outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write 0xA0 then 0xAA, then STOP -> ACK low on both 9th bits; wr_data=0xAA with exactly one wr_valid pulse; busy 1→0 after STOP.
- Address 0xA4 (7'h52) then data -> sda_oe never asserted; state goes to IGNORE, then IDLE on STOP; no wr_valid.
- Read 0xA1 with rd_data=0xCC, master ACK, rd_data=0xF0, master NACK -> SDA bits 11001100 then 11110000; two rd_req pulses; IGNORE after NACK.
- Write 0xA0, 0x11, repeated START, 0xA1 -> wr_data=0x11; new address ACKed; read path entered with no STOP in between.
- STOP after 4 bits of a data byte -> IDLE, wr_data unchanged, sda_oe=0.
- reset=0 while driving ACK -> sda_oe=0 and state=IDLE on the next clk edge; after reset, the next valid address is ACKed normally.
